univ_shift_reg: RTL
===================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range WIDTH >= 2.
REQ-002 Parameter RST_VAL, default 0, WIDTH-bit value loaded into Q on reset.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 EN  input  1  clock enable; 0 = all state holds.
REQ-006 MODE  input  3  operation select, encoding per REQ-012.
REQ-007 D  input  WIDTH  parallel load data.
REQ-008 SIN_R  input  1  serial input entering the MSB on right shift.
REQ-009 SIN_L  input  1  serial input entering the LSB on left shift.
REQ-010 Q  output  WIDTH  register contents, registered.
REQ-011 Further outputs SHALL be: SOR (1, = Q[0], combinational from Q); SOL (1, = Q[WIDTH-1], combinational from Q); CO (1, registered carry/borrow/shift-out flag); ZERO (1, combinational, = 1 iff Q == 0).

Function
REQ-012 On a rising CLK edge with RST=0 and EN=1, Q SHALL update per MODE:
 - 000 HOLD: Q unchanged.
 - 001 LOAD: Q <= D.
 - 010 SHR: Q <= {SIN_R, Q[WIDTH-1:1]}.
 - 011 SHL: Q <= {Q[WIDTH-2:0], SIN_L}.
 - 100 ROTR: Q <= {Q[0], Q[WIDTH-1:1]}.
 - 101 ROTL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
 - 110 INC: Q <= (Q + 1) mod 2^WIDTH.
 - 111 DEC: Q <= (Q - 1) mod 2^WIDTH.
REQ-013 CO SHALL update on the same edge as Q:
 - HOLD: CO unchanged.
 - LOAD: CO <= 0.
 - SHR, ROTR: CO <= old Q[0].
 - SHL, ROTL: CO <= old Q[WIDTH-1].
 - INC: CO <= 1 iff old Q is all ones.
 - DEC: CO <= 1 iff old Q == 0.
REQ-014 Latency SHALL be one cycle: the result of an operation sampled at edge N is visible on Q/CO after edge N.
REQ-015 With EN=0, Q and CO SHALL hold regardless of MODE, D, SIN_R and SIN_L.
REQ-016 Wrap-around SHALL occur without saturation:
 - INC from all-ones gives 0.
 - DEC from 0 gives all-ones.
REQ-017 MODE changes take effect on the next enabled edge; the block has no multi-cycle operations or internal state beyond Q and CO.
REQ-018 SOR, SOL and ZERO SHALL be pure functions of the current Q, with no added cycle delay.

Reset
REQ-019 On a rising edge with RST=1, Q SHALL become RST_VAL and CO SHALL become 0, regardless of EN and MODE.
REQ-020 RST SHALL have priority over EN and MODE: a reset asserted during any operation, including mid-way through an INC/DEC run, discards that edge's operation.
REQ-021 Before the first reset edge, output values are unspecified; the bench SHALL assert RST for at least one edge before checking outputs.

Verification (WIDTH=8, RST_VAL=0)
REQ-022 Reset priority: RST=1, EN=1, MODE=LOAD, D=0xAA for one edge -> Q=0x00, CO=0, ZERO=1.
REQ-023 Load and shift right: LOAD D=0xA5, then SHR with SIN_R=1 -> after first edge Q=0xA5, CO=0; after second edge Q=0xD2, CO=1, SOR=0, SOL=1.
REQ-024 Shift vs rotate left: from Q=0x81, SHL with SIN_L=0 -> Q=0x02, CO=1. Reload 0x81, then ROTL -> Q=0x03, CO=1.
REQ-025 Counter wrap: from Q=0xFF, INC -> Q=0x00, CO=1, ZERO=1. Then DEC -> Q=0xFF, CO=1. Then DEC -> Q=0xFE, CO=0.
REQ-026 Enable gating: Q=0x10, MODE=INC, EN=0 for 3 edges -> Q stays 0x10 and CO unchanged. Set EN=1 for 1 edge -> Q=0x11.
REQ-027 Reset mid-run: INC from 0x00 for 5 edges (Q=0x05), RST=1 on the 6th edge -> Q=0x00, CO=0. Deassert RST, INC continues -> Q=0x01.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, parallel load, shift, rotate, increment and decrement,
// with a registered carry/borrow/shift-out flag and combinational serial-out and zero taps.
module univ_shift_reg #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIN_R,
    input  logic             SIN_L,
    output logic [WIDTH-1:0] Q,
    output logic             SOR,
    output logic             SOL,
    output logic             CO,
    output logic             ZERO
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_SHL  = 3'b011;
    localparam logic [2:0] MODE_ROTR = 3'b100;
    localparam logic [2:0] MODE_ROTL = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             co_reg;
    logic             co_next;

    always_comb begin
        q_next  = q_reg;
        co_next = co_reg;
        if (EN) begin
            unique case (MODE)
                MODE_HOLD: begin
                    q_next  = q_reg;
                    co_next = co_reg;
                end
                MODE_LOAD: begin
                    q_next  = D;
                    co_next = 1'b0;
                end
                MODE_SHR: begin
                    q_next  = {SIN_R, q_reg[WIDTH-1:1]};
                    co_next = q_reg[0];
                end
                MODE_SHL: begin
                    q_next  = {q_reg[WIDTH-2:0], SIN_L};
                    co_next = q_reg[WIDTH-1];
                end
                MODE_ROTR: begin
                    q_next  = {q_reg[0], q_reg[WIDTH-1:1]};
                    co_next = q_reg[0];
                end
                MODE_ROTL: begin
                    q_next  = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                    co_next = q_reg[WIDTH-1];
                end
                // Counter modes wrap modulo 2^WIDTH; CO flags the wrap.
                MODE_INC: begin
                    q_next  = q_reg + ONE;
                    co_next = (q_reg == ALL_ONES);
                end
                MODE_DEC: begin
                    q_next  = q_reg - ONE;
                    co_next = (q_reg == '0);
                end
                default: begin
                    q_next  = q_reg;
                    co_next = co_reg;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_reg  <= RST_VAL;
            co_reg <= 1'b0;
        end else begin
            q_reg  <= q_next;
            co_reg <= co_next;
        end
    end

    assign Q    = q_reg;
    assign CO   = co_reg;
    assign SOR  = q_reg[0];
    assign SOL  = q_reg[WIDTH-1];
    assign ZERO = (q_reg == '0);

endmodule
